adc_readout_seq: RTL and testbench
==================================

Name: adc_readout_seq

Overview:
- Readout sequencer directly downstream of the per-chip ADC deserializers inside the ADC frontend.
- On a trigger, starts a capture on every enabled chip and waits for all captures to finish.
- Then drains each chip's sample buffer in chip order and packs the samples into a 32-bit word stream with valid/ready handshake, for the event builder.
- Also provides the busy, error and overrun status the frontend reports on its control interface.

Parameters:
- N_CHIPS, 8: number of deserializer instances served; chip index is 3 bits wide.
- N_SAMPLES, 64: samples per channel held in each deserializer buffer per capture.
- ADC_W, 14: ADC sample width; valid range 1..16.
- TIMEOUT, 65535: maximum number of clk cycles spent in WAIT_DONE.

Ports:
- clk  in  1  150 MHz system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- trigger  in  1  single-cycle start request.
- chip_mask  in  N_CHIPS  enable per chip; sampled at trigger acceptance.
- begin_sample  out  N_CHIPS  one-cycle capture start pulse per chip.
- deser_busy  in  N_CHIPS  deserializer capturing; rises the cycle after begin_sample, falls when the buffer is full.
- buffer_rdreq  out  N_CHIPS  buffer read strobe; data is valid 1 cycle later.
- buffer_data_a/b/c/d  in  N_CHIPS*ADC_W each  flattened buffer outputs; chip i occupies bits [i*ADC_W +: ADC_W].
- out_data  out  32  packed output word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the word.
- busy  out  1  high whenever the state is not IDLE.
- timeout_err  out  1  sticky; cleared only by the next accepted trigger.
- overrun_cnt  out  8  saturating count of triggers dropped while busy.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; counters 0. Reset mid-readout abandons the event; no partial-word cleanup.
- States: IDLE, ARM, WAIT_DONE, HEADER, READ, CAPTURE, EMIT_AB, EMIT_CD, NEXT_CHIP.
- IDLE:
  - trigger=1 with chip_mask≠0: latch the mask, clear timeout_err, go to ARM.
  - trigger=1 with chip_mask=0: ignored; no state change, no counter change.
- ARM (1 cycle): begin_sample = latched mask. Go to WAIT_DONE. Trigger-to-begin_sample latency is exactly 1 cycle.
- WAIT_DONE:
  - The cycle after ARM is a guard cycle; deser_busy is ignored in it.
  - Thereafter, when (deser_busy & mask)==0, set chip index to the lowest enabled chip and go to HEADER.
  - If the cycle counter reaches TIMEOUT first: set timeout_err, go to IDLE, emit nothing.
- HEADER:
  - out_data = {8'hA5, 5'd0, chip[2:0], N_SAMPLES[15:0]}, out_valid=1.
  - On out_ready, clear sample counter and go to READ.
- READ (1 cycle): buffer_rdreq[chip]=1. Go to CAPTURE.
- CAPTURE (1 cycle): register all four channel samples of the current chip. Go to EMIT_AB.
- EMIT_AB:
  - out_data = {zero-ext a to 16 bits, zero-ext b to 16 bits}, a in [31:16]; out_valid=1.
  - On out_ready, go to EMIT_CD.
- EMIT_CD:
  - Same packing with c in [31:16] and d in [15:0].
  - On out_ready: if the sample counter is N_SAMPLES-1, go to NEXT_CHIP; else increment the counter and go to READ.
- NEXT_CHIP: advance to the next higher enabled chip and go to HEADER; if none remains, go to IDLE.
- Handshake:
  - out_data is held stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
  - One transfer per cycle at most.
- Output volume: per enabled chip, 1 + 2*N_SAMPLES words; chips appear in ascending index order.
- Trigger while busy=1: ignored; overrun_cnt increments, saturating at 255.
- busy=1 from the cycle after trigger acceptance until the cycle the state returns to IDLE.
- begin_sample and buffer_rdreq are never asserted for chips masked off.
- A change on chip_mask during an event has no effect.

Test Plan:
- Single-chip event: chip_mask=8'h04, N_SAMPLES=4, deser_busy[2] high for 10 cycles, out_ready=1.
  -> begin_sample=8'h04 exactly 1 cycle after trigger.
  -> 9 words: header 32'hA5020004, then 8 data words matching the buffer contents.
  -> busy drops after the last word.
- Multi-chip ordering: chip_mask=8'h81.
  -> chip 0 block first, then chip 7 block.
  -> 18 words total with N_SAMPLES=4.
  -> buffer_rdreq never asserted on chips 1..6.
- Backpressure: out_ready toggled randomly at 50%.
  -> out_data stable whenever out_valid=1 and out_ready=0.
  -> no word lost or duplicated; sample a=14'h3FFF produces 32'h3FFFxxxx.
- Timeout: TIMEOUT=100, deser_busy[0] stuck high.
  -> timeout_err=1 and return to IDLE at 100 cycles after WAIT_DONE entry, with no out_valid.
  -> next trigger clears timeout_err.
- Overrun and empty mask:
  -> 300 triggers during one readout give overrun_cnt=255.
  -> a trigger with chip_mask=0 in IDLE gives busy=0 and no begin_sample.
- Asynchronous reset mid-EMIT_AB: reset pulled low between clock edges.
  -> out_valid, busy and buffer_rdreq go to 0 immediately.
  -> after release, a fresh trigger produces a complete, correct event.

Source files
------------

// File: rtl/adc_readout_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc_readout_seq_if
// Purpose  : Word-stream handshake between the readout sequencer and the
//            event builder. One 32-bit word moves per cycle at most, on any
//            clock edge where out_valid and out_ready are both high.
// Signals  : out_data  [31:0]  packed header / sample word (source -> sink)
//            out_valid         out_data holds a word      (source -> sink)
//            out_ready         sink accepts the word      (sink -> source)
// Modports : master = word source (sequencer), slave = word sink.
// Revision : 1.0  initial release
// ============================================================================
interface adc_readout_seq_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface : adc_readout_seq_if
`default_nettype wire

// File: rtl/adc_readout_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc_readout_seq
// Purpose  : Readout sequencer behind the per-chip ADC deserializers. A
//            trigger starts a capture on every enabled chip; once all of
//            them have finished, each chip's buffer is drained in ascending
//            chip order and packed into 32-bit words:
//              header : {8'hA5, chip index (8b), N_SAMPLES[15:0]}
//              data   : {a, b} then {c, d}, each channel zero-extended to 16b
//            giving 1 + 2*N_SAMPLES words per enabled chip.
// Ports    : clk            system clock (only clock)
//            reset          asynchronous, active-low reset
//            trigger        single-cycle start request
//            chip_mask      per-chip enable, sampled when a trigger is accepted
//            begin_sample   one-cycle capture start pulse per chip
//            deser_busy     per-chip capture in progress
//            buffer_rdreq   per-chip buffer read strobe (data one cycle later)
//            buffer_data_*  flattened channel a/b/c/d buffer outputs,
//                           chip i at [i*ADC_W +: ADC_W]
//            out_if         word stream to the event builder (master side)
//            busy           sequencer not idle
//            timeout_err    sticky capture timeout, cleared by next accepted
//                           trigger
//            overrun_cnt    saturating count of triggers dropped while busy
// Revision : 1.0  initial release
// ============================================================================
module adc_readout_seq #(
  parameter int N_CHIPS   = 8,
  parameter int N_SAMPLES = 64,
  parameter int ADC_W     = 14,
  parameter int TIMEOUT   = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trigger,
  input  logic [N_CHIPS-1:0]       chip_mask,
  output logic [N_CHIPS-1:0]       begin_sample,
  input  logic [N_CHIPS-1:0]       deser_busy,
  output logic [N_CHIPS-1:0]       buffer_rdreq,
  input  logic [N_CHIPS*ADC_W-1:0] buffer_data_a,
  input  logic [N_CHIPS*ADC_W-1:0] buffer_data_b,
  input  logic [N_CHIPS*ADC_W-1:0] buffer_data_c,
  input  logic [N_CHIPS*ADC_W-1:0] buffer_data_d,
  adc_readout_seq_if.master        out_if,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [7:0]               overrun_cnt
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  localparam int CHIP_W = (N_CHIPS > 1) ? $clog2(N_CHIPS) : 1;
  localparam int CNT_W  = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(N_SAMPLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT - 1);
  localparam logic [15:0]      HDR_NSAMP   = 16'(N_SAMPLES);
  localparam logic [7:0]       HDR_TAG     = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ARM       = 4'd1,
    S_WAIT_DONE = 4'd2,
    S_HEADER    = 4'd3,
    S_READ      = 4'd4,
    S_CAPTURE   = 4'd5,
    S_EMIT_AB   = 4'd6,
    S_EMIT_CD   = 4'd7,
    S_NEXT_CHIP = 4'd8
  } state_t;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t              state_q;
  logic [N_CHIPS-1:0]  mask_q;
  logic [CHIP_W-1:0]   chip_q;
  logic [CNT_W-1:0]    smp_cnt_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [ADC_W-1:0]    c_q;
  logic [ADC_W-1:0]    d_q;
  logic [31:0]         out_data_q;
  logic                out_valid_q;
  logic [N_CHIPS-1:0]  begin_sample_q;
  logic [N_CHIPS-1:0]  buffer_rdreq_q;
  logic                busy_q;
  logic                timeout_err_q;
  logic [7:0]          overrun_q;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic logic [15:0] zext16(input logic [ADC_W-1:0] v);
    logic [15:0] r;
    r            = '0;
    r[ADC_W-1:0] = v;
    return r;
  endfunction

  function automatic logic [31:0] header_word(input logic [CHIP_W-1:0] ch);
    return {HDR_TAG, 8'(ch), HDR_NSAMP};
  endfunction

  // Lowest enabled chip (start of the drain) and the next enabled chip above
  // the current one. Scanning downwards lets the last hit win, which is the
  // lowest qualifying index in both cases.
  logic [CHIP_W-1:0] first_chip_d;
  logic [CHIP_W-1:0] next_chip_d;
  logic              next_found_d;

  always_comb begin
    first_chip_d = '0;
    next_chip_d  = '0;
    next_found_d = 1'b0;
    for (int i = N_CHIPS - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        first_chip_d = CHIP_W'(i);
      end
      if (mask_q[i] && (i > int'(chip_q))) begin
        next_chip_d  = CHIP_W'(i);
        next_found_d = 1'b1;
      end
    end
  end

  // Current chip's channel samples out of the flattened buffer buses.
  logic [ADC_W-1:0] smp_a;
  logic [ADC_W-1:0] smp_b;
  logic [ADC_W-1:0] smp_c;
  logic [ADC_W-1:0] smp_d;

  assign smp_a = buffer_data_a[int'(chip_q) * ADC_W +: ADC_W];
  assign smp_b = buffer_data_b[int'(chip_q) * ADC_W +: ADC_W];
  assign smp_c = buffer_data_c[int'(chip_q) * ADC_W +: ADC_W];
  assign smp_d = buffer_data_d[int'(chip_q) * ADC_W +: ADC_W];

  // Read strobe for the current chip; gated with the latched mask so a
  // disabled chip can never be strobed.
  logic [N_CHIPS-1:0] chip_onehot;
  assign chip_onehot = (N_CHIPS'(1) << chip_q) & mask_q;

  logic all_done;
  assign all_done = ((deser_busy & mask_q) == '0);

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      mask_q         <= '0;
      chip_q         <= '0;
      smp_cnt_q      <= '0;
      to_cnt_q       <= '0;
      c_q            <= '0;
      d_q            <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      begin_sample_q <= '0;
      buffer_rdreq_q <= '0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      overrun_q      <= '0;
    end else begin
      // Strobes are single-cycle unless a state below re-asserts them.
      begin_sample_q <= '0;
      buffer_rdreq_q <= '0;

      // Any trigger outside IDLE is dropped and counted.
      if (trigger && (state_q != S_IDLE) && (overrun_q != 8'hFF)) begin
        overrun_q <= overrun_q + 8'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (trigger && (chip_mask != '0)) begin
            mask_q         <= chip_mask;
            timeout_err_q  <= 1'b0;
            // Launched at acceptance so the pulse is visible in ARM.
            begin_sample_q <= chip_mask;
            busy_q         <= 1'b1;
            state_q        <= S_ARM;
          end
        end

        S_ARM: begin
          to_cnt_q <= '0;
          state_q  <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          // to_cnt_q == 0 marks the guard cycle: the deserializers have not
          // yet had a chance to raise busy, so completion is not trusted.
          if ((to_cnt_q != '0) && all_done) begin
            chip_q      <= first_chip_d;
            out_data_q  <= header_word(first_chip_d);
            out_valid_q <= 1'b1;
            state_q     <= S_HEADER;
          end else if (to_cnt_q == TO_LAST) begin
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end

        S_HEADER: begin
          if (out_if.out_ready) begin
            out_valid_q    <= 1'b0;
            smp_cnt_q      <= '0;
            buffer_rdreq_q <= chip_onehot;
            state_q        <= S_READ;
          end
        end

        S_READ: begin
          // Strobe is on the bus during this cycle; data follows next cycle.
          state_q <= S_CAPTURE;
        end

        S_CAPTURE: begin
          // a/b go straight into the output word; c/d are held for EMIT_CD.
          c_q         <= smp_c;
          d_q         <= smp_d;
          out_data_q  <= {zext16(smp_a), zext16(smp_b)};
          out_valid_q <= 1'b1;
          state_q     <= S_EMIT_AB;
        end

        S_EMIT_AB: begin
          if (out_if.out_ready) begin
            out_data_q <= {zext16(c_q), zext16(d_q)};
            state_q    <= S_EMIT_CD;
          end
        end

        S_EMIT_CD: begin
          if (out_if.out_ready) begin
            out_valid_q <= 1'b0;
            if (smp_cnt_q == LAST_SAMPLE) begin
              state_q <= S_NEXT_CHIP;
            end else begin
              smp_cnt_q      <= smp_cnt_q + CNT_W'(1);
              buffer_rdreq_q <= chip_onehot;
              state_q        <= S_READ;
            end
          end
        end

        S_NEXT_CHIP: begin
          if (next_found_d) begin
            chip_q      <= next_chip_d;
            out_data_q  <= header_word(next_chip_d);
            out_valid_q <= 1'b1;
            state_q     <= S_HEADER;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign begin_sample     = begin_sample_q;
  assign buffer_rdreq     = buffer_rdreq_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign busy             = busy_q;
  assign timeout_err      = timeout_err_q;
  assign overrun_cnt      = overrun_q;

endmodule : adc_readout_seq
`default_nettype wire

// File: tb/tb_adc_readout_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_adc_readout_seq
// Purpose  : Self-checking bench for adc_readout_seq (N_SAMPLES=4,
//            TIMEOUT=100). Models the deserializers (busy pulse, buffered
//            samples with one-cycle read latency) and the stream sink.
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_readout_seq;

  localparam int NC = 8;
  localparam int NS = 4;
  localparam int AW = 14;
  localparam int TO = 100;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             trigger = 1'b0;
  logic [NC-1:0]    chip_mask = '0;
  logic [NC-1:0]    begin_sample;
  logic [NC-1:0]    deser_busy = '0;
  logic [NC-1:0]    buffer_rdreq;
  logic [NC*AW-1:0] buffer_data_a = '0;
  logic [NC*AW-1:0] buffer_data_b = '0;
  logic [NC*AW-1:0] buffer_data_c = '0;
  logic [NC*AW-1:0] buffer_data_d = '0;
  logic             busy;
  logic             timeout_err;
  logic [7:0]       overrun_cnt;

  adc_readout_seq_if out_if ();

  adc_readout_seq #(
    .N_CHIPS   (NC),
    .N_SAMPLES (NS),
    .ADC_W     (AW),
    .TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .trigger       (trigger),
    .chip_mask     (chip_mask),
    .begin_sample  (begin_sample),
    .deser_busy    (deser_busy),
    .buffer_rdreq  (buffer_rdreq),
    .buffer_data_a (buffer_data_a),
    .buffer_data_b (buffer_data_b),
    .buffer_data_c (buffer_data_c),
    .buffer_data_d (buffer_data_d),
    .out_if        (out_if),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .overrun_cnt   (overrun_cnt)
  );

  always #3 clk = ~clk;

  // Controls written only by the main process.
  int         rmode = 0;        // 0 always ready, 1 random, 2 never, 3 until ready_limit
  int         ready_limit = 0;
  int         blen = 10;
  bit         stuck = 1'b0;
  logic [7:0] ev_mask = '0;

  // Observations written only by the model / monitor processes.
  logic [31:0] got_q[$];
  int          stab_err = 0;
  int          valid_cnt = 0;
  int          bad_rd = 0;
  int          bad_bs = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Buffer contents: unique per chip/sample/channel (bit 8 always set), with
  // one full-scale value on chip 3 sample 1 channel a.
  function automatic logic [13:0] smp(input int chip, input int s, input int ch);
    if (chip == 3 && s == 1 && ch == 0) return 14'h3FFF;
    return 14'((chip << 11) | (ch << 9) | 256 | (s & 255));
  endfunction

  // ---------------- deserializer model ----------------
  int bcnt[NC];
  int ptr[NC];
  bit bs_pend[NC];
  bit rd_pend[NC];

  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (rd_pend[i]) begin
        buffer_data_a[i*AW +: AW] = smp(i, ptr[i], 0);
        buffer_data_b[i*AW +: AW] = smp(i, ptr[i], 1);
        buffer_data_c[i*AW +: AW] = smp(i, ptr[i], 2);
        buffer_data_d[i*AW +: AW] = smp(i, ptr[i], 3);
        ptr[i]++;
        rd_pend[i] = 1'b0;
      end else begin
        buffer_data_a[i*AW +: AW] = 14'h2AAA;
        buffer_data_b[i*AW +: AW] = 14'h2AAA;
        buffer_data_c[i*AW +: AW] = 14'h2AAA;
        buffer_data_d[i*AW +: AW] = 14'h2AAA;
      end
      if (bs_pend[i]) begin
        deser_busy[i] = 1'b1;
        bcnt[i]       = blen;
        bs_pend[i]    = 1'b0;
      end else if (deser_busy[i] && !stuck) begin
        bcnt[i]--;
        if (bcnt[i] <= 0) deser_busy[i] = 1'b0;
      end
      if (begin_sample[i]) begin
        bs_pend[i] = 1'b1;
        ptr[i]     = 0;
        if (!ev_mask[i]) bad_bs++;
      end
      if (buffer_rdreq[i]) begin
        rd_pend[i] = 1'b1;
        if (!ev_mask[i]) bad_rd++;
      end
    end
  end

  // ---------------- stream sink / monitor ----------------
  logic        mon_r = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (prev_stall && reset) begin
      if (!out_if.out_valid || (out_if.out_data !== prev_data)) stab_err++;
    end
    case (rmode)
      0:       mon_r = 1'b1;
      1:       mon_r = 1'($urandom_range(0, 1));
      2:       mon_r = 1'b0;
      default: mon_r = (got_q.size() < ready_limit);
    endcase
    out_if.out_ready = mon_r;
    if (out_if.out_valid) valid_cnt++;
    if (out_if.out_valid && mon_r && reset) got_q.push_back(out_if.out_data);
    prev_stall = out_if.out_valid && !mon_r;
    prev_data  = out_if.out_data;
  end

  // ---------------- checking helpers ----------------
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic build_exp(input logic [7:0] mask);
    exp_q.delete();
    for (int c = 0; c < NC; c++) begin
      if (mask[c]) begin
        exp_q.push_back({8'hA5, 5'd0, 3'(c), 16'(NS)});
        for (int s = 0; s < NS; s++) begin
          exp_q.push_back({2'b00, smp(c, s, 0), 2'b00, smp(c, s, 1)});
          exp_q.push_back({2'b00, smp(c, s, 2), 2'b00, smp(c, s, 3)});
        end
      end
    end
  endtask

  task automatic cmp_stream(input int start);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (start + i < got_q.size())
        chk($sformatf("word %0d", i), got_q[start + i], exp_q[i]);
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    int cyc;
    cyc = 0;
    while (busy && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  // One complete event with full checking.
  task automatic run_event(input logic [7:0] mask, input int rm, input int bl,
                           input int nwords, output int start);
    int rd0, bs0, st0;
    rmode = rm; blen = bl; ev_mask = mask;
    start = got_q.size();
    rd0 = bad_rd; bs0 = bad_bs; st0 = stab_err;
    build_exp(mask);
    chip_mask = mask;
    trigger   = 1'b1;
    @(negedge clk);
    trigger   = 1'b0;
    chip_mask = ~mask;                    // must not affect the running event
    chk("begin_sample latency", {24'd0, begin_sample}, {24'd0, mask});
    chk("busy after accept", {31'd0, busy}, 32'd1);
    chk("timeout_err cleared", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    chk("begin_sample pulse", {24'd0, begin_sample}, 32'd0);
    wait_idle("event completes", 5000);
    chk("word count", got_q.size() - start, nwords);
    cmp_stream(start);
    chk("rdreq on masked chip", bad_rd - rd0, 0);
    chk("begin_sample on masked chip", bad_bs - bs0, 0);
    chk("stall stability", stab_err - st0, 0);
  endtask

  typedef struct {
    logic [7:0] mask;
    int         rmode;
    int         blen;
    int         nwords;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int st, cyc, v0;

    tbl[0] = '{8'h04, 0, 10, 9};
    tbl[1] = '{8'h81, 0, 10, 18};
    tbl[2] = '{8'h08, 1, 6, 9};
    tbl[3] = '{8'hFF, 1, 3, 72};
    tbl[4] = '{8'h5A, 1, 20, 36};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset out_valid", {31'd0, out_if.out_valid}, 32'd0);
    chk("reset begin_sample", {24'd0, begin_sample}, 32'd0);
    chk("reset buffer_rdreq", {24'd0, buffer_rdreq}, 32'd0);
    chk("reset timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("reset overrun_cnt", {24'd0, overrun_cnt}, 32'd0);
    chk("reset out_data", out_if.out_data, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // ---- table-driven events ----
    for (int k = 0; k < 5; k++) begin
      run_event(tbl[k].mask, tbl[k].rmode, tbl[k].blen, tbl[k].nwords, st);
      if (tbl[k].mask == 8'h08 && got_q.size() > st + 3)
        chk("full-scale a", {16'd0, got_q[st + 3][31:16]}, 32'h3FFF);
      repeat (3) @(negedge clk);
    end
    chk("first header", got_q[0], 32'hA5020004);

    // ---- timeout ----
    rmode = 0; blen = 10; ev_mask = 8'h01; stuck = 1'b1;
    v0 = valid_cnt; st = got_q.size();
    chip_mask = 8'h01; trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (TO) @(negedge clk);
    chk("timeout: still waiting", {30'd0, busy, timeout_err}, 32'h2);
    @(negedge clk);
    chk("timeout: idle with error", {30'd0, busy, timeout_err}, 32'h1);
    chk("timeout: no output", valid_cnt - v0, 0);
    chk("timeout: no words", got_q.size() - st, 0);
    stuck = 1'b0;
    cyc = 0;
    while (deser_busy != '0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("timeout_err sticky", {31'd0, timeout_err}, 32'd1);
    run_event(8'h02, 0, 4, 9, st);

    // ---- overrun saturation ----
    rmode = 2; blen = 5; ev_mask = 8'h01;
    st = got_q.size();
    build_exp(8'h01);
    chip_mask = 8'h01; trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (3) @(negedge clk);
    trigger = 1'b1;
    repeat (200) @(negedge clk);
    trigger = 1'b0;
    chk("overrun 200", {24'd0, overrun_cnt}, 32'd200);
    trigger = 1'b1;
    repeat (100) @(negedge clk);
    trigger = 1'b0;
    chk("overrun saturates", {24'd0, overrun_cnt}, 32'd255);
    chk("busy during overrun", {31'd0, busy}, 32'd1);
    rmode = 0;
    wait_idle("overrun event completes", 2000);
    chk("overrun event words", got_q.size() - st, 9);
    cmp_stream(st);

    // ---- empty mask ----
    repeat (2) @(negedge clk);
    chip_mask = 8'h00; trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    chk("empty mask busy", {31'd0, busy}, 32'd0);
    chk("empty mask begin_sample", {24'd0, begin_sample}, 32'd0);
    chk("empty mask overrun", {24'd0, overrun_cnt}, 32'd255);
    @(negedge clk);
    chk("empty mask still idle", {24'd0, begin_sample, 7'd0, busy}, 32'd0);

    // ---- asynchronous reset inside EMIT_AB ----
    rmode = 3; blen = 4; ev_mask = 8'h01;
    st = got_q.size();
    ready_limit = st + 1;
    chip_mask = 8'h01; trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    cyc = 0;
    while (!(out_if.out_valid && got_q.size() == st + 1 && out_if.out_data[31:24] != 8'hA5)
           && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("EMIT_AB word before reset", out_if.out_data, {2'b00, smp(0, 0, 0), 2'b00, smp(0, 0, 1)});
    #1 reset = 1'b0;
    #1;
    chk("async reset out_valid", {31'd0, out_if.out_valid}, 32'd0);
    chk("async reset busy", {31'd0, busy}, 32'd0);
    chk("async reset rdreq", {24'd0, buffer_rdreq}, 32'd0);
    chk("async reset overrun", {24'd0, overrun_cnt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    rmode = 0;
    cyc = 0;
    while (deser_busy != '0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    run_event(8'h10, 1, 6, 9, st);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_adc_readout_seq
`default_nettype wire
